// File: rtl/grant_lock_pkg.sv
// Shared types and helpers for the grant lock controller.
// Optional watchdog in grant_lock_ctrl is enabled by GRANT_LOCK_TIMEOUT_EN.
package grant_lock_pkg;

  // Helpers operate on a fixed maximum width; callers zero-extend.
  localparam int unsigned GL_MAX_N     = 32;
  localparam int unsigned GL_MAX_IDX_W = 5;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    XFER    = 2'd1,
    RELEASE = 2'd2
  } gl_state_e;

  // True when exactly one bit is set.
  function automatic logic is_onehot(input logic [GL_MAX_N-1:0] v);
    int unsigned ones;
    ones = 0;
    for (int unsigned i = 0; i < GL_MAX_N; i++) begin
      ones = ones + 32'(v[i]);
    end
    return (ones == 1);
  endfunction

  // Binary index of a one-hot vector (zero for an all-zero vector).
  function automatic logic [GL_MAX_IDX_W-1:0] onehot_to_idx(input logic [GL_MAX_N-1:0] v);
    logic [GL_MAX_IDX_W-1:0] idx;
    idx = '0;
    for (int unsigned i = 0; i < GL_MAX_N; i++) begin
      if (v[i]) idx = idx | GL_MAX_IDX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/onehot_to_bin.sv
// Combinational one-hot to binary encoder for the owner index.
module onehot_to_bin
  import grant_lock_pkg::*;
#(
  parameter int unsigned N     = 4,
  parameter int unsigned IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     i_oh,
  output logic [IDX_W-1:0] o_idx
);

  assign o_idx = IDX_W'(onehot_to_idx(GL_MAX_N'(i_oh)));

endmodule

// File: rtl/grant_lock_ctrl.sv
// Locks a one-hot arbiter grant as owner for a multi-beat burst and
// drives a valid/ready handshake toward the shared resource.
// Define GRANT_LOCK_TIMEOUT_EN to build the stall watchdog.
module grant_lock_ctrl
  import grant_lock_pkg::*;
#(
  parameter int unsigned N       = 4,
  parameter int unsigned LEN_W   = 4,
  parameter int unsigned IDX_W   = $clog2(N),
  parameter int unsigned TIMEOUT = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [N-1:0]     i_grant,
  input  logic [N-1:0]     i_request,
  input  logic [LEN_W-1:0] i_len,
  input  logic             i_ready,
  output logic             o_valid,
  output logic             o_busy,
  output logic [IDX_W-1:0] o_owner,
  output logic [N-1:0]     o_owner_oh,
  output logic [LEN_W-1:0] o_beat_cnt,
  output logic             o_done,
  output logic             o_abort,
  output logic             o_timeout,
  output logic             o_err
);

  gl_state_e        state_q, state_d;
  logic [N-1:0]     owner_oh_q, owner_oh_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic             normal_q, normal_d;
  logic             err_q, err_d;
  logic             owner_req;
  logic             beat;

`ifdef GRANT_LOCK_TIMEOUT_EN
  localparam int unsigned STALL_W = $clog2(TIMEOUT) + 1;
  logic [STALL_W-1:0] stall_q, stall_d;
  logic               tmo_q, tmo_d;
`endif

  assign owner_req = |(i_request & owner_oh_q);
  assign beat      = (state_q == XFER) && i_ready;

  // Next-state logic: grant capture, beat counting, release and abort.
  always_comb begin
    state_d    = state_q;
    owner_oh_d = owner_oh_q;
    len_d      = len_q;
    cnt_d      = cnt_q;
    normal_d   = normal_q;
    err_d      = err_q;
`ifdef GRANT_LOCK_TIMEOUT_EN
    stall_d    = '0;
    tmo_d      = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        if (i_grant != '0) begin
          if (is_onehot(GL_MAX_N'(i_grant))) begin
            owner_oh_d = i_grant;
            len_d      = i_len;
            cnt_d      = '0;
            state_d    = XFER;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      XFER: begin
        // Owner withdrawal outranks a beat and the watchdog in the same cycle.
        if (!owner_req) begin
          normal_d = 1'b0;
          state_d  = RELEASE;
        end else if (beat) begin
          if (cnt_q == len_q) begin
            normal_d = 1'b1;
            state_d  = RELEASE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
`ifdef GRANT_LOCK_TIMEOUT_EN
        else if (stall_q == STALL_W'(TIMEOUT - 1)) begin
          normal_d = 1'b0;
          tmo_d    = 1'b1;
          state_d  = RELEASE;
        end else begin
          stall_d = stall_q + 1'b1;
        end
`endif
      end
      RELEASE: begin
        owner_oh_d = '0;
        cnt_d      = '0;
        normal_d   = 1'b0;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with asynchronous clear.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= IDLE;
      owner_oh_q <= '0;
      len_q      <= '0;
      cnt_q      <= '0;
      normal_q   <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_oh_q <= owner_oh_d;
      len_q      <= len_d;
      cnt_q      <= cnt_d;
      normal_q   <= normal_d;
      err_q      <= err_d;
    end
  end

`ifdef GRANT_LOCK_TIMEOUT_EN
  // Stall counter and watchdog-abort flag for the release cycle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      stall_q <= '0;
      tmo_q   <= 1'b0;
    end else begin
      stall_q <= stall_d;
      tmo_q   <= tmo_d;
    end
  end
  assign o_timeout = (state_q == RELEASE) && tmo_q;
`else
  assign o_timeout = 1'b0;
`endif

  onehot_to_bin #(.N(N), .IDX_W(IDX_W)) u_enc (
    .i_oh  (owner_oh_q),
    .o_idx (o_owner)
  );

  assign o_valid    = (state_q == XFER);
  assign o_busy     = (state_q != IDLE);
  assign o_owner_oh = owner_oh_q;
  assign o_beat_cnt = cnt_q;
  assign o_done     = (state_q == RELEASE) && normal_q;
  assign o_abort    = (state_q == RELEASE) && !normal_q;
  assign o_err      = err_q;

endmodule

// File: tb/tb_grant_lock_ctrl.sv
// Directed, table-driven bench for grant_lock_ctrl (N=4, LEN_W=4).
// Honours GRANT_LOCK_TIMEOUT_EN for the stall scenario.
module tb_grant_lock_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] grant, req, len;
  logic       rdy;
  logic       valid, busy, done, abort, tmo, err;
  logic [1:0] owner;
  logic [3:0] oh, cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  grant_lock_ctrl #(.N(4), .LEN_W(4), .IDX_W(2), .TIMEOUT(16)) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_grant    (grant),
    .i_request  (req),
    .i_len      (len),
    .i_ready    (rdy),
    .o_valid    (valid),
    .o_busy     (busy),
    .o_owner    (owner),
    .o_owner_oh (oh),
    .o_beat_cnt (cnt),
    .o_done     (done),
    .o_abort    (abort),
    .o_timeout  (tmo),
    .o_err      (err)
  );

  typedef struct {
    logic [3:0] grant, req, len;
    logic       rdy;
    logic       valid, busy;
    logic [1:0] owner;
    logic [3:0] oh, cnt;
    logic       done, abort, err;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic [3:0] g, logic [3:0] r, logic [3:0] l, logic rd,
                              logic v, logic b, logic [1:0] ow, logic [3:0] o,
                              logic [3:0] c, logic d, logic a, logic e);
    vec_t t;
    t.grant = g; t.req = r; t.len = l; t.rdy = rd;
    t.valid = v; t.busy = b; t.owner = ow; t.oh = o; t.cnt = c;
    t.done = d; t.abort = a; t.err = e;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string tag, input logic v, input logic b, input logic [1:0] ow,
                         input logic [3:0] o, input logic [3:0] c, input logic d,
                         input logic a, input logic t, input logic e);
    chk({tag, ".valid"},   32'(valid), 32'(v));
    chk({tag, ".busy"},    32'(busy),  32'(b));
    chk({tag, ".owner"},   32'(owner), 32'(ow));
    chk({tag, ".owner_oh"},32'(oh),    32'(o));
    chk({tag, ".beat_cnt"},32'(cnt),   32'(c));
    chk({tag, ".done"},    32'(done),  32'(d));
    chk({tag, ".abort"},   32'(abort), 32'(a));
    chk({tag, ".timeout"}, 32'(tmo),   32'(t));
    chk({tag, ".err"},     32'(err),   32'(e));
  endtask

  task automatic drive(input logic [3:0] g, input logic [3:0] r, input logic [3:0] l, input logic rd);
    grant = g; req = r; len = l; rdy = rd;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; grant = '0; req = '0; len = '0; rdy = 1'b0;

    // Burst with owner 2, len 2, always ready.
    tbl.push_back(mk(4'b0100, 4'b0100, 4'd2, 1, 1, 1, 2, 4'b0100, 0, 0, 0, 0));
    tbl.push_back(mk(4'b0000, 4'b0100, 4'd2, 1, 1, 1, 2, 4'b0100, 1, 0, 0, 0));
    tbl.push_back(mk(4'b0000, 4'b0100, 4'd2, 1, 1, 1, 2, 4'b0100, 2, 0, 0, 0));
    tbl.push_back(mk(4'b0000, 4'b0100, 4'd2, 1, 0, 1, 2, 4'b0100, 2, 1, 0, 0));
    tbl.push_back(mk(4'b0000, 4'b0000, 4'd0, 1, 0, 0, 0, 4'b0000, 0, 0, 0, 0));
    // Owner 0, len 5, ready toggling, request withdrawn after 2 beats.
    tbl.push_back(mk(4'b0001, 4'b0001, 4'd5, 0, 1, 1, 0, 4'b0001, 0, 0, 0, 0));
    tbl.push_back(mk(4'b0000, 4'b0001, 4'd5, 0, 1, 1, 0, 4'b0001, 0, 0, 0, 0));
    tbl.push_back(mk(4'b0000, 4'b0001, 4'd5, 1, 1, 1, 0, 4'b0001, 1, 0, 0, 0));
    tbl.push_back(mk(4'b0000, 4'b0001, 4'd5, 0, 1, 1, 0, 4'b0001, 1, 0, 0, 0));
    tbl.push_back(mk(4'b0000, 4'b0001, 4'd5, 1, 1, 1, 0, 4'b0001, 2, 0, 0, 0));
    tbl.push_back(mk(4'b0000, 4'b0000, 4'd5, 1, 0, 1, 0, 4'b0001, 2, 0, 1, 0));
    tbl.push_back(mk(4'b0000, 4'b0000, 4'd0, 0, 0, 0, 0, 4'b0000, 0, 0, 0, 0));
    // Owner 1, len 3; competing grant 4'b1000 ignored until after release.
    tbl.push_back(mk(4'b0010, 4'b0010, 4'd3, 1, 1, 1, 1, 4'b0010, 0, 0, 0, 0));
    tbl.push_back(mk(4'b1000, 4'b1010, 4'd0, 1, 1, 1, 1, 4'b0010, 1, 0, 0, 0));
    tbl.push_back(mk(4'b1000, 4'b1010, 4'd0, 1, 1, 1, 1, 4'b0010, 2, 0, 0, 0));
    tbl.push_back(mk(4'b1000, 4'b1010, 4'd0, 1, 1, 1, 1, 4'b0010, 3, 0, 0, 0));
    tbl.push_back(mk(4'b1000, 4'b1010, 4'd0, 1, 0, 1, 1, 4'b0010, 3, 1, 0, 0));
    tbl.push_back(mk(4'b1000, 4'b1000, 4'd0, 1, 0, 0, 0, 4'b0000, 0, 0, 0, 0));
    // Captured in first IDLE cycle; single-beat burst (len 0).
    tbl.push_back(mk(4'b1000, 4'b1000, 4'd0, 0, 1, 1, 3, 4'b1000, 0, 0, 0, 0));
    tbl.push_back(mk(4'b0000, 4'b1000, 4'd0, 1, 0, 1, 3, 4'b1000, 0, 1, 0, 0));
    tbl.push_back(mk(4'b0000, 4'b0000, 4'd0, 1, 0, 0, 0, 4'b0000, 0, 0, 0, 0));
    // Malformed grant sets sticky error; later clean grant still runs.
    tbl.push_back(mk(4'b0110, 4'b0110, 4'd1, 1, 0, 0, 0, 4'b0000, 0, 0, 0, 1));
    tbl.push_back(mk(4'b0000, 4'b0110, 4'd1, 1, 0, 0, 0, 4'b0000, 0, 0, 0, 1));
    tbl.push_back(mk(4'b0010, 4'b0010, 4'd1, 1, 1, 1, 1, 4'b0010, 0, 0, 0, 1));
    tbl.push_back(mk(4'b0000, 4'b0010, 4'd1, 1, 1, 1, 1, 4'b0010, 1, 0, 0, 1));
    tbl.push_back(mk(4'b0000, 4'b0010, 4'd1, 1, 0, 1, 1, 4'b0010, 1, 1, 0, 1));
    tbl.push_back(mk(4'b0000, 4'b0000, 4'd0, 1, 0, 0, 0, 4'b0000, 0, 0, 0, 1));

    // Reset state, held and then released with idle inputs.
    repeat (2) @(posedge clk);
    #1;
    chk_all("reset", 0, 0, 0, 4'b0000, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drive(4'b0000, 4'b0000, 4'd0, 0);
      chk_all($sformatf("idle%0d", i), 0, 0, 0, 4'b0000, 0, 0, 0, 0, 0);
    end

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].grant, tbl[i].req, tbl[i].len, tbl[i].rdy);
      chk_all($sformatf("vec%0d", i), tbl[i].valid, tbl[i].busy, tbl[i].owner, tbl[i].oh,
              tbl[i].cnt, tbl[i].done, tbl[i].abort, 1'b0, tbl[i].err);
    end

    // Stall: owner 0 locked, ready low for 20 cycles.
    drive(4'b0001, 4'b0001, 4'd0, 0);
    chk_all("stall_lock", 1, 1, 0, 4'b0001, 0, 0, 0, 0, 1);
    for (int k = 1; k <= 20; k++) begin
      drive(4'b0000, 4'b0001, 4'd0, 0);
`ifdef GRANT_LOCK_TIMEOUT_EN
      if (k < 16)
        chk_all($sformatf("stall%0d", k), 1, 1, 0, 4'b0001, 0, 0, 0, 0, 1);
      else if (k == 16)
        chk_all($sformatf("stall%0d", k), 0, 1, 0, 4'b0001, 0, 0, 1, 1, 1);
      else
        chk_all($sformatf("stall%0d", k), 0, 0, 0, 4'b0000, 0, 0, 0, 0, 1);
`else
      chk_all($sformatf("stall%0d", k), 1, 1, 0, 4'b0001, 0, 0, 0, 0, 1);
`endif
    end
`ifndef GRANT_LOCK_TIMEOUT_EN
    drive(4'b0000, 4'b0001, 4'd0, 1);
    chk_all("stall_end", 0, 1, 0, 4'b0001, 0, 1, 0, 0, 1);
`endif
    drive(4'b0000, 4'b0000, 4'd0, 0);
    chk_all("stall_idle", 0, 0, 0, 4'b0000, 0, 0, 0, 0, 1);

    // Asynchronous reset in the middle of a burst.
    drive(4'b0100, 4'b0100, 4'd3, 1);
    chk_all("mid_lock", 1, 1, 2, 4'b0100, 0, 0, 0, 0, 1);
    drive(4'b0000, 4'b0100, 4'd3, 1);
    chk_all("mid_beat", 1, 1, 2, 4'b0100, 1, 0, 0, 0, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all("mid_reset", 0, 0, 0, 4'b0000, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(4'b0000, 4'b0100, 4'd3, 1);
    chk_all("post_reset", 0, 0, 0, 4'b0000, 0, 0, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/grant_lock_ctrl.md
Name: grant_lock_ctrl

Overview:
- Sits directly downstream of the N-bit fixed-priority arbiter and consumes its registered one-hot grant.
- Locks the granted requester as owner of a shared resource for a multi-beat burst, and drives a valid/ready handshake toward the resource.
- Releases ownership on the last beat, or aborts when the owner withdraws its request.
- Reports the owner index and flags malformed (non-one-hot) grants.

Parameters:
- N, 4: number of requesters; width of grant and request vectors.
- LEN_W, 4: width of the burst-length field. A burst is i_len+1 beats.
- IDX_W, $clog2(N): width of the owner index.
- TIMEOUT, 16: stall-cycle limit; used only with the optional feature.

Ports:
- i_clk  in  1  clock; all logic on rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_grant  in  N  one-hot grant from the arbiter; all-zero means no grant.
- i_request  in  N  raw request vector, same vector the arbiter sees.
- i_len  in  LEN_W  burst length minus one; sampled with the grant.
- i_ready  in  1  resource accepts the current beat.
- o_valid  out  1  beat offered to the resource.
- o_busy  out  1  a burst is locked, or the release cycle is in progress.
- o_owner  out  IDX_W  binary index of the locked requester.
- o_owner_oh  out  N  one-hot of the locked requester; zero when idle.
- o_beat_cnt  out  LEN_W  beats completed in the current burst.
- o_done  out  1  one-cycle pulse when a burst ends normally.
- o_abort  out  1  one-cycle pulse when a burst ends early.
- o_timeout  out  1  one-cycle pulse on watchdog abort; tied 0 without the feature.
- o_err  out  1  sticky: a non-one-hot grant was seen.

Behaviour:
- Reset (i_rst_n=0, asynchronous): state IDLE. Every output is 0: o_valid, o_busy, o_owner, o_owner_oh, o_beat_cnt, o_done, o_abort, o_timeout, o_err. Length register is 0.
- States: IDLE, XFER, RELEASE.
- IDLE:
  - i_grant == 0: stay in IDLE.
  - i_grant exactly one-hot: capture o_owner_oh=i_grant, o_owner=encoded index, len_q=i_len, o_beat_cnt=0; go to XFER.
  - i_grant with more than one bit set: set o_err (sticky until reset), capture nothing, stay in IDLE.
- XFER:
  - o_valid=1 and o_busy=1; o_valid is asserted the cycle after the grant is sampled (latency 1).
  - A beat completes when o_valid && i_ready.
  - If the beat completes with o_beat_cnt==len_q: go to RELEASE with a normal-end flag. Otherwise o_beat_cnt increments.
  - If i_request[o_owner]==0: the abort has priority over any beat in the same cycle. That beat is not counted, o_valid drops next cycle, go to RELEASE with the abort flag.
  - i_grant is ignored throughout XFER and RELEASE; it is never queued.
- RELEASE (exactly one cycle):
  - o_busy=1, o_valid=0.
  - o_done=1 if normal end, otherwise o_abort=1.
  - Next state IDLE, where o_owner_oh, o_owner and o_beat_cnt clear to 0.
  - A grant can be captured in the first IDLE cycle after RELEASE.
- Burst length i_len=0 gives a single beat: XFER lasts until the first handshake, then RELEASE.
- o_beat_cnt never wraps; maximum value is len_q.
- Back-to-back timing: grant at cycle t → XFER t+1 → with i_ready=1, last beat at t+1+len → RELEASE at t+2+len → IDLE at t+3+len.
- Reset mid-burst clears everything immediately. No o_done or o_abort is generated.

Optional Feature:
- Macro GRANT_LOCK_TIMEOUT_EN.
- Defined:
  - A stall counter increments each XFER cycle with o_valid && !i_ready, and clears on any completed beat or on leaving XFER.
  - When the counter reaches TIMEOUT-1 while still stalled: go to RELEASE with o_abort=1 and o_timeout=1 in the same cycle.
  - Owner withdrawal in the same cycle takes precedence; o_abort only, o_timeout stays 0.
- Undefined: no stall counter is built, o_timeout is constant 0, and the port list is unchanged.

Decomposition:
- Package grant_lock_pkg:
  - state enum (IDLE, XFER, RELEASE);
  - function is_onehot(N-bit);
  - function onehot_to_idx.
- One sub-module, onehot_to_bin #(N): combinational one-hot to binary encoder feeding o_owner.
- Counters and the FSM stay in grant_lock_ctrl.

Test Plan (N=4, LEN_W=4):
- Reset release, all inputs 0, 10 cycles → every output stays 0, state IDLE.
- i_grant=4'b0100, i_len=2, i_request=4'b0100, i_ready=1 → o_valid high 3 cycles, o_owner=2, o_owner_oh=4'b0100, o_beat_cnt 0→1→2. o_done pulses one cycle after the 3rd beat; idle the cycle after that.
- i_grant=4'b0001, i_len=5, i_ready toggling, i_request[0] dropped after 2 beats → o_abort pulse, o_done=0, o_beat_cnt=2 in the release cycle, back to IDLE.
- Lock owner 1 with i_len=3, then drive i_grant=4'b1000 during XFER → ignored; owner stays 1. After release, grant 4'b1000 is captured with o_owner=3.
- i_grant=4'b0110 while idle → o_err=1 and stays set, no o_valid. A later clean grant 4'b0010 still runs a burst and o_err remains 1.
- With GRANT_LOCK_TIMEOUT_EN, TIMEOUT=16: owner 0 locked, i_ready=0 for 20 cycles → o_timeout and o_abort pulse on the 16th stalled cycle. Without the macro → no abort, o_valid held 20 cycles.
